// File: rtl/seq_divider61_11_pkg.sv
// Shared widths, FSM encoding and constants for the 61/11-bit sequential divider.
package seq_divider61_11_pkg;

    localparam int unsigned DIVIDEND_W = 61;
    localparam int unsigned DIVISOR_W  = 11;
    localparam int unsigned ITER_CNT_W = 6;
    localparam int unsigned REM_W      = DIVISOR_W + 1;

    // Counter start value: one iteration per dividend bit, counting down to zero.
    localparam logic [ITER_CNT_W-1:0] ITER_LAST = ITER_CNT_W'(DIVIDEND_W - 1);

    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider61_11_sub.sv
// 12-bit unsigned ripple-borrow subtractor used for the restoring trial subtract.
module unsigned_subtractor12
    import seq_divider61_11_pkg::*;
(
    input  logic [REM_W-1:0] a,
    input  logic [REM_W-1:0] b,
    output logic [REM_W-1:0] diff,
    output logic             borrow
);

    logic [REM_W:0] bw;

    always_comb begin
        bw   = '0;
        diff = '0;
        for (int unsigned i = 0; i < REM_W; i++) begin
            diff[i]  = a[i] ^ b[i] ^ bw[i];
            bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
        borrow = bw[REM_W];
    end

endmodule

// File: rtl/seq_divider61_11.sv
// Multi-cycle unsigned restoring divider, 61-bit dividend by 11-bit divisor,
// with valid/ready handshakes on request and result sides.
module seq_divider61_11
    import seq_divider61_11_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] Quotient,
    output logic [DIVISOR_W-1:0]  Remainder,
    output logic                  div_by_zero
);

    div_state_t            state;
    logic [DIVIDEND_W-1:0] dvd_sr;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic [REM_W-1:0]      rem_r;
    logic [ITER_CNT_W-1:0] cnt_r;
    logic [DIVIDEND_W-1:0] q_r;
    logic [DIVISOR_W-1:0]  r_r;
    logic                  dbz_r;

    logic [REM_W-1:0]      trial;
    logic [REM_W-1:0]      diff;
    logic                  borrow;
    logic                  q_bit;
    logic [REM_W-1:0]      rem_nxt;
    logic [DIVIDEND_W-1:0] dvd_nxt;
    logic                  accept;
    logic                  last_iter;

    // Handshake flags come straight from registered state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign accept    = in_valid && (state == IDLE);
    assign last_iter = (cnt_r == '0);

    assign trial = {rem_r[DIVISOR_W-1:0], dvd_sr[DIVIDEND_W-1]};

    unsigned_subtractor12 u_sub (
        .a      (trial),
        .b      ({1'b0, dvs_r}),
        .diff   (diff),
        .borrow (borrow)
    );

    // The dividend register doubles as the quotient register: bits shift out
    // of the top into the trial value while quotient bits enter at the bottom.
    always_comb begin
        q_bit   = ~borrow;
        rem_nxt = borrow ? trial : diff;
        dvd_nxt = {dvd_sr[DIVIDEND_W-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= (B == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sr <= '0;
            dvs_r  <= '0;
            rem_r  <= '0;
            cnt_r  <= '0;
        end else if (accept) begin
            dvd_sr <= A;
            dvs_r  <= B;
            rem_r  <= '0;
            cnt_r  <= ITER_LAST;
        end else if (state == BUSY) begin
            dvd_sr <= dvd_nxt;
            rem_r  <= rem_nxt;
            if (!last_iter) begin
                cnt_r <= cnt_r - ITER_CNT_W'(1);
            end
        end
    end

    // Result registers load only when a division completes, so they hold
    // steady through DONE and any backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else if (accept && (B == '0)) begin
            q_r   <= DBZ_QUOTIENT;
            r_r   <= A[DIVISOR_W-1:0];
            dbz_r <= 1'b1;
        end else if ((state == BUSY) && last_iter) begin
            q_r   <= dvd_nxt;
            r_r   <= rem_nxt[DIVISOR_W-1:0];
            dbz_r <= 1'b0;
        end
    end

    assign Quotient    = q_r;
    assign Remainder   = r_r;
    assign div_by_zero = dbz_r;

endmodule
